// File: rtl/fir_sched_pkg.sv
// Shared types and default sizing for the FIR access scheduler.
// Imported by the scheduler top and its sample FIFO.
package fir_sched_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_NUM_COEFF  = 4;
    localparam int DEF_TIMEOUT    = 64;

    localparam int IDX_W   = $clog2(DEF_NUM_COEFF);
    localparam int TIMER_W = $clog2(DEF_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DR1,
        DR2,
        LC,
        ACK,
        DONE
    } state_t;

    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO, DATA_W x DEPTH, with full/empty/count.
// Push while full and pop while empty are ignored.
module fir_sample_fifo
    import fir_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    parameter int PW     = bits_for(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [PW:0]       count
);

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (PW + 1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_access_scheduler.sv
// Front-end sequencer for the FIR core: buffers samples and coefficient
// sets and drives the core's dr/lc/data handshake.
module fir_access_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NUM_COEFF  = DEF_NUM_COEFF,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    input  logic              coeff_valid,
    input  logic [DATA_W-1:0] coeff_data,
    output logic              coeff_ready,
    output logic              fir_dr,
    output logic              fir_lc,
    output logic [DATA_W-1:0] fir_data,
    input  logic              fir_modwait,
    input  logic              fir_err,
    input  logic              clear_status,
    output logic              busy,
    output logic              err_sticky,
    output logic              timeout_sticky
);

    localparam int PW = bits_for(FIFO_DEPTH);
    localparam int IW = bits_for(NUM_COEFF);
    localparam int SW = $clog2(NUM_COEFF + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] FULL_SET = SW'(NUM_COEFF);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_COEFF - 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     idx_nxt;
    logic [TW-1:0]     timer_q, timer_d;
    logic [SW-1:0]     staged_q, staged_d;
    logic              loading_q, loading_d;
    logic              fir_dr_q, fir_dr_d;
    logic              fir_lc_q, fir_lc_d;
    logic [DATA_W-1:0] fir_data_q, fir_data_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [DATA_W-1:0] coeff_q [NUM_COEFF];
    logic [DATA_W-1:0] coeff_d [NUM_COEFF];

    logic              fifo_push;
    logic              fifo_pop;
    logic              pop_req;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW:0]       fifo_count;
    logic              coeff_push;
    logic              retire;
    logic              finish;

    assign sample_ready   = !fifo_full;
    assign coeff_ready    = (staged_q < FULL_SET) && !loading_q;
    assign fir_dr         = fir_dr_q;
    assign fir_lc         = fir_lc_q;
    assign fir_data       = fir_data_q;
    assign busy           = (state_q != IDLE);
    assign err_sticky     = err_q;
    assign timeout_sticky = tmo_q;

    assign fifo_push  = sample_valid && !fifo_full;
    assign fifo_pop   = pop_req && !fifo_empty;
    assign coeff_push = coeff_valid && coeff_ready;
    assign idx_nxt    = idx_q + IW'(1);

    fir_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .PW     (PW)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (fifo_push),
        .wdata (sample_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        staged_d   = staged_q;
        loading_d  = loading_q;
        fir_dr_d   = 1'b0;
        fir_lc_d   = 1'b0;
        fir_data_d = fir_data_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        coeff_d    = coeff_q;
        pop_req    = 1'b0;
        retire     = 1'b0;
        finish     = 1'b0;

        if (clear_status) begin
            err_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (coeff_push) begin
            coeff_d[staged_q[IW-1:0]] = coeff_data;
            staged_d = staged_q + SW'(1);
        end

        unique case (state_q)
            IDLE: begin
                // A complete coefficient set outranks queued samples.
                if (staged_q == FULL_SET) begin
                    state_d    = LC;
                    idx_d      = '0;
                    loading_d  = 1'b1;
                    fir_lc_d   = 1'b1;
                    fir_data_d = coeff_q[0];
                end else if (fifo_count != '0) begin
                    state_d    = DR1;
                    fir_dr_d   = 1'b1;
                    fir_data_d = fifo_head;
                end
            end
            DR1: begin
                fir_dr_d = 1'b1;
                state_d  = DR2;
            end
            DR2: begin
                if (fir_modwait) begin
                    state_d = DONE;
                    timer_d = '0;
                end else begin
                    retire = 1'b1;
                end
            end
            LC: begin
                state_d = ACK;
                timer_d = '0;
            end
            ACK: begin
                if (fir_modwait) begin
                    state_d = DONE;
                    timer_d = '0;
                end else if (timer_q != '0) begin
                    retire = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                if (!fir_modwait) begin
                    if (fir_err) begin
                        err_d = 1'b1;
                    end
                    if (loading_q && (idx_q != LAST_IDX)) begin
                        idx_d      = idx_nxt;
                        state_d    = LC;
                        fir_lc_d   = 1'b1;
                        fir_data_d = coeff_q[idx_nxt];
                    end else begin
                        finish = 1'b1;
                    end
                end else if (timer_q == TMO_LIM) begin
                    retire = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (retire) begin
            tmo_d = 1'b1;
        end
        // Timeout and normal completion both retire the transaction.
        if (retire || finish) begin
            state_d    = IDLE;
            fir_data_d = '0;
            if (loading_q) begin
                staged_d  = '0;
                loading_d = 1'b0;
            end else begin
                pop_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            staged_q   <= '0;
            loading_q  <= 1'b0;
            fir_dr_q   <= 1'b0;
            fir_lc_q   <= 1'b0;
            fir_data_q <= '0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            for (int i = 0; i < NUM_COEFF; i++) begin
                coeff_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            staged_q   <= staged_d;
            loading_q  <= loading_d;
            fir_dr_q   <= fir_dr_d;
            fir_lc_q   <= fir_lc_d;
            fir_data_q <= fir_data_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            coeff_q    <= coeff_d;
        end
    end

endmodule
